// File: rtl/iris_axil_pkg.sv
// Shared response codes, FSM state types and helpers for the iris AXI-Lite memory.
package iris_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_MEM  = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_MEM  = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/iris_axil_mem_if.sv
// AXI-Lite channel bundle between a gw5ast_core master port and the iris memory.
interface iris_axil_mem_if #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  axi_awvalid;
  logic                  axi_awready;
  logic [ADDR_WIDTH-1:0] axi_awaddr;
  logic                  axi_wvalid;
  logic                  axi_wready;
  logic [DATA_WIDTH-1:0] axi_wdata;
  logic [3:0]            axi_wstrb;
  logic                  axi_wlast;
  logic                  axi_bvalid;
  logic                  axi_bready;
  logic [1:0]            axi_bresp;
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic [ADDR_WIDTH-1:0] axi_araddr;
  logic                  axi_rvalid;
  logic                  axi_rready;
  logic [DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rlast;

  modport master (
    output axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
           axi_bready, axi_arvalid, axi_araddr, axi_rready,
    input  axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_arready,
           axi_rvalid, axi_rdata, axi_rresp, axi_rlast
  );

  modport slave (
    input  axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
           axi_bready, axi_arvalid, axi_araddr, axi_rready,
    output axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_arready,
           axi_rvalid, axi_rdata, axi_rresp, axi_rlast
  );
endinterface

// File: rtl/iris_sp_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module iris_sp_ram #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned BYTES      = DATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [BYTES-1:0]         be_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto a RAM macro; only the output register clears.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/iris_axil_mem.sv
// AXI-Lite slave memory: independent write/read FSMs sharing one RAM port, writes first.
// Define IRIS_MEM_BOUNDS_CHECK_EN to answer out-of-range addresses with SLVERR instead of aliasing.
module iris_axil_mem
  import iris_axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 1024
) (
  input logic            clk,
  input logic            rst,
  iris_axil_mem_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned BYTES = DATA_WIDTH / 8;

  w_state_e              w_state_q, w_state_d;
  logic                  aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;

  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [1:0]            rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs, r_issue, w_err, r_err;
  logic ram_we, ram_re;
  logic [IDX_W-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

`ifdef IRIS_MEM_BOUNDS_CHECK_EN
  assign w_err = 32'(awaddr_q) >= DEPTH;
  assign r_err = 32'(araddr_q) >= DEPTH;
  logic unused;
  assign unused = &{1'b0, bus.axi_wlast, wstrb_q};
`else
  assign w_err = 1'b0;
  assign r_err = 1'b0;
  logic unused;
  assign unused = &{1'b0, bus.axi_wlast, wstrb_q,
                    awaddr_q[ADDR_WIDTH-1:IDX_W], araddr_q[ADDR_WIDTH-1:IDX_W]};
`endif

  assign bus.axi_awready = !rst && (w_state_q == W_IDLE) && !aw_full_q;
  assign bus.axi_wready  = !rst && (w_state_q == W_IDLE) && !w_full_q;
  assign bus.axi_bvalid  = (w_state_q == W_RESP);
  assign bus.axi_bresp   = bresp_q;
  assign aw_hs = bus.axi_awvalid && bus.axi_awready;
  assign w_hs  = bus.axi_wvalid && bus.axi_wready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    w_state_d = w_state_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_full_d = 1'b1;
          awaddr_d  = bus.axi_awaddr;
        end
        if (w_hs) begin
          w_full_d = 1'b1;
          wdata_d  = bus.axi_wdata;
          wstrb_d  = bus.axi_wstrb;
        end
        if (aw_full_d && w_full_d) w_state_d = W_MEM;
      end
      W_MEM: begin
        aw_full_d = 1'b0;
        w_full_d  = 1'b0;
        bresp_d   = resp_of(w_err);
        w_state_d = W_RESP;
      end
      W_RESP:  if (bus.axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  assign bus.axi_arready = !rst && (r_state_q == R_IDLE);
  assign bus.axi_rvalid  = (r_state_q == R_RESP);
  assign bus.axi_rlast   = (r_state_q == R_RESP);
  assign bus.axi_rresp   = rresp_q;
  assign bus.axi_rdata   = (rresp_q == RESP_SLVERR) ? '0 : ram_rdata;
  assign ar_hs   = bus.axi_arvalid && bus.axi_arready;
  // The write FSM owns the RAM port whenever it sits in W_MEM; the read simply retries.
  assign r_issue = (r_state_q == R_MEM) && (w_state_q != W_MEM);

  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: if (ar_hs) begin
        araddr_d  = bus.axi_araddr;
        r_state_d = R_MEM;
      end
      R_MEM: if (r_issue) begin
        rresp_d   = resp_of(r_err);
        r_state_d = R_RESP;
      end
      R_RESP:  if (bus.axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      rresp_q   <= rresp_d;
    end
  end

  assign ram_we   = (w_state_q == W_MEM) && !w_err && !rst;
  assign ram_re   = r_issue && !r_err && !rst;
  assign ram_addr = (w_state_q == W_MEM) ? awaddr_q[IDX_W-1:0] : araddr_q[IDX_W-1:0];

  iris_sp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .BYTES      (BYTES)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .be_i    (wstrb_q[BYTES-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_iris_axil_mem.sv
// Self-checking bench for iris_axil_mem: directed cases then random traffic vs. a word-array model.
module tb_iris_axil_mem;
  import iris_axil_pkg::*;

  localparam int DW    = 24;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;
`ifdef IRIS_MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iris_axil_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  iris_axil_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem   [DEPTH];
  logic [2:0]    ref_known [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                           input logic [3:0] s);
    int idx;
    if (BOUNDS && a >= DEPTH) return RESP_SLVERR;
    idx = int'(a) % DEPTH;
    for (int b = 0; b < 3; b++) begin
      if (s[b]) begin
        ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        ref_known[idx][b] = 1'b1;
      end
    end
    return RESP_OKAY;
  endfunction

  function automatic void ref_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                                   output logic [DW-1:0] mask, output logic [1:0] resp);
    int idx;
    if (BOUNDS && a >= DEPTH) begin
      d = '0; mask = '1; resp = RESP_SLVERR;
      return;
    end
    idx  = int'(a) % DEPTH;
    d    = ref_mem[idx];
    mask = '0;
    for (int b = 0; b < 3; b++) if (ref_known[idx][b]) mask[8*b +: 8] = 8'hFF;
    resp = RESP_OKAY;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return AW'(DEPTH + $urandom_range(0, 15));
      1:       return AW'($urandom_range(DEPTH, 65535));
      default: return AW'($urandom_range(0, 31));
    endcase
  endfunction

  // Called one tick after a clock edge; w_lead > 0 presents W that many cycles before AW.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int w_lead, input int b_hold);
    logic [1:0] exp_resp;
    bit aw_done, w_done, aw_hs, w_hs;
    int k, lat, aw_start, w_start;
    exp_resp = ref_write(addr, data, strb);
    aw_done = 0; w_done = 0; k = 0;
    aw_start = (w_lead > 0) ? w_lead : 0;
    w_start  = (w_lead < 0) ? -w_lead : 0;
    while (!(aw_done && w_done) && k < 50) begin
      if (!aw_done && k >= aw_start) begin
        bus.axi_awvalid = 1'b1; bus.axi_awaddr = addr;
      end
      if (!w_done && k >= w_start) begin
        bus.axi_wvalid = 1'b1; bus.axi_wdata = data; bus.axi_wstrb = strb; bus.axi_wlast = 1'b1;
      end
      aw_hs = bus.axi_awvalid && bus.axi_awready;
      w_hs  = bus.axi_wvalid && bus.axi_wready;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1; bus.axi_awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  bus.axi_wvalid  = 1'b0; end
      k++;
    end
    bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
    check("wr_handshake", 32'(aw_done && w_done), 32'd1);
    lat = 0;
    while (!bus.axi_bvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("wr_bvalid", 32'(bus.axi_bvalid), 32'd1);
    check("wr_latency", 32'(lat), 32'd1);
    check("wr_bresp", 32'(bus.axi_bresp), 32'(exp_resp));
    for (int i = 0; i < b_hold; i++) begin
      @(posedge clk); #1;
      check("wr_hold_bvalid", 32'(bus.axi_bvalid), 32'd1);
      check("wr_hold_bresp", 32'(bus.axi_bresp), 32'(exp_resp));
      check("wr_hold_awready", 32'(bus.axi_awready), 32'd0);
      check("wr_hold_wready", 32'(bus.axi_wready), 32'd0);
    end
    bus.axi_bready = 1'b1;
    @(posedge clk); #1;
    bus.axi_bready = 1'b0;
    check("wr_bvalid_drop", 32'(bus.axi_bvalid), 32'd0);
  endtask

  // Expected data is taken from the model once the response arrives, after any racing write.
  task automatic axi_read(input logic [AW-1:0] addr, input int r_hold, input int exp_lat);
    logic [DW-1:0] exp_d, mask;
    logic [1:0] exp_resp;
    bit hs, done;
    int k, lat;
    done = 0; k = 0;
    bus.axi_arvalid = 1'b1; bus.axi_araddr = addr;
    while (!done && k < 50) begin
      hs = bus.axi_arvalid && bus.axi_arready;
      @(posedge clk); #1;
      if (hs) done = 1;
      k++;
    end
    bus.axi_arvalid = 1'b0;
    check("rd_handshake", 32'(done), 32'd1);
    lat = 0;
    while (!bus.axi_rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    ref_read(addr, exp_d, mask, exp_resp);
    check("rd_rvalid", 32'(bus.axi_rvalid), 32'd1);
    check("rd_rlast", 32'(bus.axi_rlast), 32'd1);
    check("rd_latency", 32'(lat), 32'(exp_lat));
    check("rd_rresp", 32'(bus.axi_rresp), 32'(exp_resp));
    if (mask != '0) check("rd_rdata", 32'(bus.axi_rdata & mask), 32'(exp_d & mask));
    for (int i = 0; i < r_hold; i++) begin
      @(posedge clk); #1;
      check("rd_hold_rvalid", 32'(bus.axi_rvalid), 32'd1);
      check("rd_hold_rresp", 32'(bus.axi_rresp), 32'(exp_resp));
      check("rd_hold_arready", 32'(bus.axi_arready), 32'd0);
      if (mask != '0) check("rd_hold_rdata", 32'(bus.axi_rdata & mask), 32'(exp_d & mask));
    end
    bus.axi_rready = 1'b1;
    @(posedge clk); #1;
    bus.axi_rready = 1'b0;
    check("rd_rvalid_drop", 32'(bus.axi_rvalid), 32'd0);
    check("rd_rlast_drop", 32'(bus.axi_rlast), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hs, done;
    int k;
    for (int i = 0; i < DEPTH; i++) ref_known[i] = 3'b000;
    rst = 1'b1;
    bus.axi_awvalid = 1'b0; bus.axi_awaddr = '0;
    bus.axi_wvalid  = 1'b0; bus.axi_wdata  = '0; bus.axi_wstrb = '0; bus.axi_wlast = 1'b0;
    bus.axi_bready  = 1'b0;
    bus.axi_arvalid = 1'b0; bus.axi_araddr = '0;
    bus.axi_rready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 32'(bus.axi_awready), 32'd0);
    check("rst_wready", 32'(bus.axi_wready), 32'd0);
    check("rst_arready", 32'(bus.axi_arready), 32'd0);
    check("rst_bvalid", 32'(bus.axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.axi_rvalid), 32'd0);
    check("rst_rlast", 32'(bus.axi_rlast), 32'd0);
    check("rst_bresp", 32'(bus.axi_bresp), 32'(RESP_OKAY));
    check("rst_rresp", 32'(bus.axi_rresp), 32'(RESP_OKAY));
    check("rst_rdata", 32'(bus.axi_rdata), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_awready", 32'(bus.axi_awready), 32'd1);
    check("idle_arready", 32'(bus.axi_arready), 32'd1);

    // Same-cycle AW/W, then readback; then W leading AW by two cycles with a middle-byte strobe.
    axi_write(16'h0010, 24'hA5B6C7, 4'b0111, 0, 0);
    axi_read(16'h0010, 0, 1);
    axi_write(16'h0010, 24'h00FF00, 4'b0010, 2, 0);
    axi_read(16'h0010, 0, 1);
    check("merge_value", 32'(ref_mem[16]), 32'h00A5FFC7);
    axi_write(16'h0010, 24'h123456, 4'b0000, -1, 0);
    axi_read(16'h0010, 0, 1);

    // Write and read to the same word land together; the read loses one cycle to W_MEM.
    fork
      axi_write(16'h0020, 24'h3C4D5E, 4'b0111, 0, 0);
      axi_read(16'h0020, 0, 2);
    join

    axi_write(16'h0021, 24'h0F1E2D, 4'b1111, 0, 5);
    axi_read(16'h0021, 5, 1);

    axi_write(16'h0000, 24'h111111, 4'b0111, 0, 0);
    axi_write(16'h0400, 24'h5A5A5A, 4'b0111, 0, 0);
    axi_read(16'h0400, 0, 1);
    axi_read(16'h0000, 0, 1);

    // AW alone is accepted, then reset discards it: no response may ever appear.
    axi_write(16'h0030, 24'h777888, 4'b0111, 1, 0);
    bus.axi_awvalid = 1'b1; bus.axi_awaddr = 16'h0031;
    done = 0; k = 0;
    while (!done && k < 20) begin
      hs = bus.axi_awvalid && bus.axi_awready;
      @(posedge clk); #1;
      if (hs) done = 1;
      k++;
    end
    bus.axi_awvalid = 1'b0;
    check("rst_aw_handshake", 32'(done), 32'd1);
    check("rst_aw_buffered", 32'(bus.axi_awready), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_wready", 32'(bus.axi_wready), 32'd0);
    check("rst_mid_arready", 32'(bus.axi_arready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst_no_bvalid", 32'(bus.axi_bvalid), 32'd0);
    end
    check("rst_aw_cleared", 32'(bus.axi_awready), 32'd1);
    axi_read(16'h0030, 0, 1);

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 1) == 0)
        axi_write(rand_addr(), DW'($urandom), 4'($urandom), int'($urandom_range(0, 4)) - 2,
                  int'($urandom_range(0, 2)));
      else
        axi_read(rand_addr(), int'($urandom_range(0, 2)), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iris_axil_mem.md
# iris_axil_mem
AXI-Lite slave memory sitting directly downstream of each gw5ast_core AXI-Lite master port; it accepts single-beat writes and reads and returns B/R responses. Storage is a single-port synchronous RAM of DEPTH words of DATA_WIDTH bits with per-byte write enables. The write and read channel FSMs are independent and share the RAM through a fixed write-priority arbiter.
## Interface
- DATA_WIDTH, 24, word width; byte lanes = DATA_WIDTH/8 (3)
- ADDR_WIDTH, 16, address width; word-addressed, no byte offset
- DEPTH, 1024, RAM words, power of two, ≤ 2^ADDR_WIDTH
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- axi_awvalid  in  1  write address valid
- axi_awready  out  1  write address ready
- axi_awaddr  in  ADDR_WIDTH  write word address
- axi_wvalid  in  1  write data valid
- axi_wready  out  1  write data ready
- axi_wdata  in  DATA_WIDTH  write data
- axi_wstrb  in  4  byte enables; bit i enables byte i for i<3, bit 3 ignored
- axi_wlast  in  1  ignored (single beat)
- axi_bvalid  out  1  write response valid
- axi_bready  in  1  write response ready
- axi_bresp  out  2  00 OKAY, 10 SLVERR
- axi_arvalid  in  1  read address valid
- axi_arready  out  1  read address ready
- axi_araddr  in  ADDR_WIDTH  read word address
- axi_rvalid  out  1  read data valid
- axi_rready  in  1  read data ready
- axi_rdata  out  DATA_WIDTH  read data
- axi_rresp  out  2  00 OKAY, 10 SLVERR
- axi_rlast  out  1  equals axi_rvalid (every response is the last beat)
## Operation
- Write FSM W_IDLE → W_MEM → W_RESP → W_IDLE. In W_IDLE, AW and W are captured independently into holding registers, in either order or same cycle; awready = W_IDLE and AW buffer empty; wready = W_IDLE and W buffer empty. Both buffers full → W_MEM.
- W_MEM: RAM write of enabled bytes (always granted); clear buffers; set bvalid, load bresp → W_RESP. W_RESP: hold bvalid/bresp stable until bready, then W_IDLE.
- Read FSM R_IDLE → R_MEM → R_RESP → R_IDLE. arready = R_IDLE; AR handshake captures address → R_MEM.
- R_MEM: issue RAM read if write FSM is not in W_MEM that cycle; else stay (write priority, one-cycle stall). Read issued → R_RESP with rvalid, rdata, rresp registered; held stable until rready.
- Same-address write and read in the same cycle: write wins, read returns new data.
- All ready outputs are 0 while rst is high.
## Timing
- Reset (rst high at edge): all FSMs idle, buffers empty; bvalid, rvalid, rlast = 0; bresp, rresp = 00; rdata = 0. RAM contents not cleared.
- Reset mid-transaction discards captured AW/W/AR and pending responses; no response is produced for them.
- Write: last of AW/W handshake at edge N → RAM written at edge N+1 → bvalid visible in cycle N+2. Throughput: one write per 3 cycles with bready held high.
- Read: AR at edge N → RAM read at edge N+1 → rvalid visible in cycle N+2; +1 cycle per W_MEM collision.
- wstrb = 0000: no bytes change, bresp still issued.
## Configuration
- IRIS_MEM_BOUNDS_CHECK_EN defined: address ≥ DEPTH → write dropped with bresp 10, read returns rdata 0 with rresp 10. Undefined: address taken modulo DEPTH (low log2(DEPTH) bits), responses always 00.
## Structure
- Package iris_axil_pkg: RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, write/read FSM state enums.
- Sub-module iris_sp_ram: single-port sync RAM, per-byte write enable, registered read data.
## Test plan
- AW and W in the same cycle, addr 0x0010, data 0xA5B6C7, wstrb 0111 → bvalid in cycle N+2, bresp 00; read of 0x0010 → rdata 0xA5B6C7, rlast 1.
- W two cycles before AW, wstrb 0010, data 0x00FF00 on word 0xA5B6C7 → readback 0xA5FFC7.
- Write and read to 0x0020 colliding in W_MEM → read stalls one cycle, returns new data.
- bready/rready held low 5 cycles → bvalid/rvalid, bresp, rdata stable; awready/arready stay 0.
- Address 0x0400 with DEPTH 1024: macro defined → bresp 10, rresp 10, rdata 0; undefined → aliases word 0x0000.
- rst asserted one cycle after AW handshake → no bvalid; earlier-written RAM data still reads back.
